// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: one-deep TX holding register plus single-byte RX
// buffer with a sticky ready flag. TX and RX run independently (full duplex).
module uart_mmio #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] WriteData,
  input  logic        Tx_MemWrite,
  input  logic        Tx_data_Memwrite,
  input  logic        Clean_rx_Memwrite,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] Rx_ReadData,
  output logic [31:0] Rx_ready_ReadData,
  output logic        Tx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic unused_wd;
  assign unused_wd = ^WriteData[31:8];

  // ---------------------------------------------------------------- TX
  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [9:0]  tx_sh;
  logic [7:0]  tx_hold;
  logic        tx_q;
  logic        tx_go, tx_tick;

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_go) tx_state_nxt = TX_START;
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    Tx_busy = (tx_state != TX_IDLE);
    tx_go   = Tx_MemWrite && WriteData[0] && (tx_state == TX_IDLE);
  end

  // Whole frame {stop, data, start} is shifted out; ones fill from the top so
  // the line naturally lands on the stop/idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_hold <= '0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      tx_q    <= 1'b1;
    end else begin
      if (Tx_data_Memwrite) tx_hold <= WriteData[7:0];
      if (tx_go) begin
        tx_sh  <= {1'b1, tx_hold, 1'b0};
        tx_q   <= 1'b0;
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (Tx_busy) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b1, tx_sh[9:1]};
          tx_q   <= tx_sh[1];
          if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------- RX
  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ferr;
  logic        rx_fall, rx_tick, rx_commit, rx_shift;

  // rx_s3 only remembers the previous synchronized level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP: begin
        // after a framing error, hold here until the line returns high
        if (rx_ferr) begin
          if (rx_s2) rx_state_nxt = RX_IDLE;
        end else if (rx_tick && rx_s2) begin
          rx_state_nxt = RX_IDLE;
        end
      end
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_fall   = rx_s3 && !rx_s2;
    rx_tick   = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    rx_shift  = (rx_state == RX_DATA) && rx_tick;
    rx_commit = (rx_state == RX_STOP) && !rx_ferr && rx_tick && rx_s2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 16'd1;
      if (rx_shift) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_state != RX_STOP)                     rx_ferr <= 1'b0;
      else if (!rx_ferr && rx_tick && !rx_s2)      rx_ferr <= 1'b1;
      if (rx_commit) rx_data <= rx_sh;
      // a completing frame beats a simultaneous clear
      rx_ready <= rx_commit || (rx_ready && !Clean_rx_Memwrite);
    end
  end

  assign Rx_ReadData       = {24'b0, rx_data};
  assign Rx_ready_ReadData = {31'b0, rx_ready};

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: frame-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_uart_mmio;
  localparam int B      = 16;
  localparam int H      = B / 2;
  localparam int RX_LAT = 3 + H + 9 * B;  // sync+edge detect, half bit, 9 bit periods

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] WriteData = '0;
  logic        Tx_MemWrite = 1'b0;
  logic        Tx_data_Memwrite = 1'b0;
  logic        Clean_rx_Memwrite = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [31:0] Rx_ReadData;
  logic [31:0] Rx_ready_ReadData;
  logic        Tx_busy;

  uart_mmio #(.BAUD_DIV(B)) dut (
    .clk(clk), .reset(reset), .WriteData(WriteData),
    .Tx_MemWrite(Tx_MemWrite), .Tx_data_Memwrite(Tx_data_Memwrite),
    .Clean_rx_Memwrite(Clean_rx_Memwrite), .rx(rx), .tx(tx),
    .Rx_ReadData(Rx_ReadData), .Rx_ready_ReadData(Rx_ready_ReadData),
    .Tx_busy(Tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [7:0] b; } rx_exp_t;
  rx_exp_t rxq[$];
  int      rx_rd = 0;
  int      cyc = 0;
  int      n_cmp = 0, n_err = 0;

  // reference model state
  logic       m_busy = 1'b0;
  int         m_a = 0;
  logic [7:0] m_byte = '0, m_hold = '0;
  logic       e_tx = 1'b1, e_rdy = 1'b0;
  logic [7:0] e_data = '0;

  always @(posedge clk or negedge reset) begin
    bit hit;
    int j;
    if (!reset) begin
      m_busy = 1'b0; m_hold = '0; e_tx = 1'b1; e_rdy = 1'b0; e_data = '0;
      rx_rd = rxq.size();
    end else begin
      cyc++;
      if (!m_busy && Tx_MemWrite && WriteData[0]) begin
        m_busy = 1'b1; m_a = cyc; m_byte = m_hold;
      end else if (m_busy && cyc - m_a >= 10 * B) begin
        m_busy = 1'b0;
      end
      if (Tx_data_Memwrite) m_hold = WriteData[7:0];
      if (m_busy) begin
        j = (cyc - m_a) / B;
        if (j == 0)      e_tx = 1'b0;
        else if (j == 9) e_tx = 1'b1;
        else             e_tx = m_byte[j-1];
      end else begin
        e_tx = 1'b1;
      end
      hit = 1'b0;
      while (rx_rd < rxq.size() && rxq[rx_rd].t <= cyc) begin
        if (rxq[rx_rd].t == cyc) begin hit = 1'b1; e_data = rxq[rx_rd].b; end
        rx_rd++;
      end
      if (hit) e_rdy = 1'b1;
      else if (Clean_rx_Memwrite) e_rdy = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) rxq.push_back('{cyc + RX_LAT, b});
    for (int j = 0; j < 10; j++) begin
      rx = f[j];
      repeat (B) begin
        step();
        if (!reset) begin rx = 1'b1; return; end
      end
    end
    rx = 1'b1;
  endtask

  // issue a TX start and sample the line mid-bit for the whole frame
  task automatic tx_capture(input logic [31:0] wd, output logic [9:0] got, output int len);
    int a, k;
    WriteData = wd; Tx_MemWrite = 1'b1;
    step();
    Tx_MemWrite = 1'b0;
    a = cyc;
    for (int j = 0; j < 10; j++) begin
      while (cyc < a + j * B + H) step();
      got[j] = tx;
    end
    k = 0;
    while (Tx_busy && k < 400) begin step(); k++; end
    chk("busy_fall_bound", 32'(Tx_busy), 32'd0);
    len = cyc - a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    int len, t;
    repeat (3) @(posedge clk);
    #1;
    fork
      forever begin
        @(negedge clk);
        chk("tx", 32'(tx), 32'(e_tx));
        chk("busy", 32'(Tx_busy), 32'(m_busy));
        chk("rxdata", Rx_ReadData, {24'b0, e_data});
        chk("rxready", Rx_ready_ReadData, {31'b0, e_rdy});
      end
    join_none
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(Tx_busy), 32'd0);
    chk("rst_rxdata", Rx_ReadData, 32'd0);
    chk("rst_rxready", Rx_ready_ReadData, 32'd0);
    reset = 1'b1;
    step();

    // single frame 0x55
    WriteData = 32'h55; Tx_data_Memwrite = 1'b1;
    step();
    Tx_data_Memwrite = 1'b0;
    tx_capture(32'h1, got, len);
    chk("tx55_bits", 32'(got), 32'b1010101010);
    chk("tx55_busy_len", 32'(len), 32'd160);

    // start + data write 20 cycles in: ignored start, frame keeps 0x55
    fork
      tx_capture(32'h1, got, len);
      begin
        repeat (20) step();
        WriteData = 32'hA3; Tx_MemWrite = 1'b1; Tx_data_Memwrite = 1'b1;
        step();
        Tx_MemWrite = 1'b0; Tx_data_Memwrite = 1'b0;
      end
    join
    chk("tx_inflight_bits", 32'(got), 32'b1010101010);
    step();
    tx_capture(32'h1, got, len);
    chk("txA3_bits", 32'(got), 32'({1'b1, 8'hA3, 1'b0}));

    // receive 0x3C, then clear
    rx_frame(8'h3C, 1'b1);
    chk("rx3C_data", Rx_ReadData, 32'h3C);
    chk("rx3C_ready", Rx_ready_ReadData, 32'd1);
    Clean_rx_Memwrite = 1'b1;
    step();
    Clean_rx_Memwrite = 1'b0;
    chk("clr_ready", Rx_ready_ReadData, 32'd0);
    chk("clr_data", Rx_ReadData, 32'h3C);

    // short glitch, then framing error
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (40) step();
    chk("glitch_ready", Rx_ready_ReadData, 32'd0);
    rx_frame(8'h81, 1'b0);
    repeat (10) step();
    chk("ferr_data", Rx_ReadData, 32'h3C);
    chk("ferr_ready", Rx_ready_ReadData, 32'd0);

    // clear on the exact completion edge
    fork
      rx_frame(8'h7E, 1'b1);
      begin
        t = cyc + RX_LAT;
        while (cyc < t - 1) step();
        Clean_rx_Memwrite = 1'b1;
        step();
        Clean_rx_Memwrite = 1'b0;
        chk("coincide_ready", Rx_ready_ReadData, 32'd1);
        chk("coincide_data", Rx_ReadData, 32'h7E);
      end
    join
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    step();
    chk("overrun_data", Rx_ReadData, 32'h22);
    chk("overrun_ready", Rx_ready_ReadData, 32'd1);

    // randomized full-duplex traffic
    fork
      begin
        repeat (3000) begin
          WriteData        = $urandom;
          Tx_data_Memwrite = ($urandom_range(0, 7) == 0);
          Tx_MemWrite      = ($urandom_range(0, 23) == 0);
          step();
        end
        Tx_data_Memwrite = 1'b0; Tx_MemWrite = 1'b0;
      end
      begin
        repeat (3000) begin
          Clean_rx_Memwrite = ($urandom_range(0, 99) == 0);
          step();
        end
        Clean_rx_Memwrite = 1'b0;
      end
      begin
        repeat (12) begin
          rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
          repeat ($urandom_range(2, 30)) step();
        end
      end
    join

    // reset mid-frame: TX in data bit 3, RX in data bit 5
    repeat (200) step();
    rx_frame(8'h5A, 1'b1);
    WriteData = 32'hB6; Tx_data_Memwrite = 1'b1;
    step();
    Tx_data_Memwrite = 1'b0;
    fork
      rx_frame(8'hC5, 1'b1);
      begin
        repeat (30) step();
        WriteData = 32'h1; Tx_MemWrite = 1'b1;
        step();
        Tx_MemWrite = 1'b0;
        repeat (69) step();
        #1 reset = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(Tx_busy), 32'd0);
        chk("midrst_rxdata", Rx_ReadData, 32'd0);
        chk("midrst_rxready", Rx_ready_ReadData, 32'd0);
        repeat (3) step();
        #1 reset = 1'b1;
      end
    join
    repeat (200) step();
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_busy", 32'(Tx_busy), 32'd0);
    chk("post_rst_rxready", Rx_ready_ReadData, 32'd0);
    chk("post_rst_rxdata", Rx_ReadData, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
